div_period_meter: RTL and testbench

Measures the half-period, in `clk` cycles, of a slow square wave such as the divided clock produced by the design's clock divider, and reports when that period is stable. It is the receiving end of the divided-clock path: the divider produces a toggling signal, and this block recovers its divide ratio. Typical use is self-check and display of the active divide ratio on the two-digit display. Everything runs in the `clk` domain; `sq_in` is treated as asynchronous.

---
 rtl/div_meter_pkg.sv | 14 +
 rtl/div_period_meter_if.sv | 40 ++++
 rtl/sync_edge.sv | 31 +++
 rtl/div_period_meter.sv | 120 ++++++++++++
 tb/tb_div_period_meter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/div_meter_pkg.sv
// Shared types and default constants for the divided-clock period meter.
package div_meter_pkg;

    // Measurement FSM: IDLE waits for a reference edge, MEAS times intervals.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    localparam int DEF_CNT_W       = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_LOCK_COUNT  = 2;

endpackage

// File: rtl/div_period_meter_if.sv
// Bundle between the square-wave source / result consumer and the meter.
//
// Handshake: meas_valid is a one-cycle qualifier for half_period with no
// backpressure (there is no ready); a consumer that wants the value must
// capture half_period in the cycle meas_valid is high. half_period itself
// holds its value until the next valid measurement.
interface div_period_meter_if #(
    parameter int CNT_W = div_meter_pkg::DEF_CNT_W
);
    import div_meter_pkg::*;

    logic             sq_in;
    logic             sq_level;
    logic [CNT_W-1:0] half_period;
    logic             meas_valid;
    logic             locked;
    logic             overflow;
    state_t           state;        // measurement FSM state, for observation

    modport master (
        output sq_in,
        input  sq_level,
        input  half_period,
        input  meas_valid,
        input  locked,
        input  overflow,
        input  state
    );

    modport slave (
        input  sq_in,
        output sq_level,
        output half_period,
        output meas_valid,
        output locked,
        output overflow,
        output state
    );

endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous level plus a change detector.
// level is the synchronized (registered) value; edge_det is high for the one
// cycle in which level differs from its previous value (either polarity).
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic edge_det
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the async input through the chain and remember the last output.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level    = sync_q[STAGES-1];
    assign edge_det = sync_q[STAGES-1] ^ prev_q;

endmodule

// File: rtl/div_period_meter.sv
// Recovers the half-period (in clk cycles) of a slow square wave, flags when
// consecutive measurements agree, and flags intervals too long to count.
module div_period_meter
    import div_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int LOCK_COUNT  = DEF_LOCK_COUNT
) (
    input  logic                clk,
    input  logic                rst,
    div_period_meter_if.slave   bus
);

    localparam int MW = (LOCK_COUNT > 2) ? $clog2(LOCK_COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [MW-1:0]    MATCH_TOP = MW'(LOCK_COUNT - 1);

    logic             sync_level;
    logic             sq_edge;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] meas;
    logic [CNT_W-1:0] last_meas;
    logic [MW-1:0]    match_cnt;
    logic [MW-1:0]    match_next;
    logic             cnt_sat;
    state_t           state;

    logic [CNT_W-1:0] half_period_q;
    logic             meas_valid_q;
    logic             locked_q;
    logic             overflow_q;

    sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .rst      (rst),
        .din      (bus.sq_in),
        .level    (sync_level),
        .edge_det (sq_edge)
    );

    // The interval ends on this edge, so it includes the edge cycle itself.
    assign meas    = cnt + CNT_W'(1);
    assign cnt_sat = (cnt == CNT_MAX);

    // Next agreement count, held at its top value once reached.
    always_comb begin
        match_next = match_cnt;
        if (match_cnt != MATCH_TOP) begin
            match_next = match_cnt + MW'(1);
        end
    end

    // Interval counter: restarts on every edge, otherwise saturating count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (sq_edge) begin
            cnt <= '0;
        end else if (!cnt_sat) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Measurement FSM with lock tracking and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            half_period_q <= '0;
            meas_valid_q  <= 1'b0;
            locked_q      <= 1'b0;
            overflow_q    <= 1'b0;
            last_meas     <= '0;
            match_cnt     <= '0;
        end else begin
            meas_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    // First edge only establishes the reference point.
                    if (sq_edge) begin
                        state <= MEAS;
                    end
                end
                MEAS: begin
                    if (cnt_sat) begin
                        // Too long to count; an edge landing here becomes
                        // the new reference edge rather than a measurement.
                        overflow_q <= 1'b1;
                        locked_q   <= 1'b0;
                        match_cnt  <= '0;
                        state      <= sq_edge ? MEAS : IDLE;
                    end else if (sq_edge) begin
                        half_period_q <= meas;
                        meas_valid_q  <= 1'b1;
                        overflow_q    <= 1'b0;
                        last_meas     <= meas;
                        if (meas == last_meas) begin
                            match_cnt <= match_next;
                            locked_q  <= (match_next == MATCH_TOP);
                        end else begin
                            match_cnt <= '0;
                            locked_q  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sq_level    = sync_level;
    assign bus.half_period = half_period_q;
    assign bus.meas_valid  = meas_valid_q;
    assign bus.locked      = locked_q;
    assign bus.overflow    = overflow_q;
    assign bus.state       = state;

endmodule

// File: tb/tb_div_period_meter.sv
// Directed and random stimulus for div_period_meter, checked every cycle
// against an edge-timing reference model.
module tb_div_period_meter;
    import div_meter_pkg::*;

    localparam int CNT_W    = DEF_CNT_W;
    localparam int SS       = DEF_SYNC_STAGES;
    localparam int LC       = DEF_LOCK_COUNT;
    localparam int SAT_SPAN = 1 << CNT_W;   // cycles after an edge at which the counter saturates

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_period_meter_if #(.CNT_W(CNT_W)) bus ();

    div_period_meter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SS),
        .LOCK_COUNT  (LC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- scoreboard / model state ----------------
    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int   ev_q[$];          // clk cycle at which each sampled input change is reported
    logic samp_hist[$];     // input as seen by the first sampling stage, last SS cycles
    logic last_samp;

    logic [CNT_W-1:0] m_hp;
    logic             m_valid, m_locked, m_ovf, m_level;
    bit               armed;
    int               last_e;
    int               run_val, run_len;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        ev_q.delete();
        samp_hist.delete();
        for (int i = 0; i < SS; i++) samp_hist.push_back(1'b0);
        last_samp = 1'b0;
        m_hp      = '0;
        m_valid   = 1'b0;
        m_locked  = 1'b0;
        m_ovf     = 1'b0;
        armed     = 1'b0;
        last_e    = 0;
        run_val   = 0;
        run_len   = 1;
    endtask

    // One clk cycle: advance the model on the edge, then compare off-edge.
    task automatic tick();
        logic s;
        bit   ev;
        int   meas;
        @(posedge clk);
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            s = bus.sq_in;
            if (s != last_samp) ev_q.push_back(cyc + SS);
            last_samp = s;
            samp_hist.push_back(s);
            void'(samp_hist.pop_front());
            m_valid = 1'b0;
            ev = (ev_q.size() > 0) && (ev_q[0] == cyc);
            if (ev) void'(ev_q.pop_front());
            if (armed && (cyc - last_e == SAT_SPAN)) begin
                m_ovf    = 1'b1;
                m_locked = 1'b0;
                run_len  = 1;
                if (ev) last_e = cyc;
                else    armed  = 1'b0;
            end else if (ev) begin
                if (armed) begin
                    meas    = cyc - last_e;
                    m_hp    = CNT_W'(meas);
                    m_valid = 1'b1;
                    m_ovf   = 1'b0;
                    if (meas == run_val) run_len++;
                    else                 run_len = 1;
                    run_val  = meas;
                    m_locked = (run_len >= LC);
                end
                armed  = 1'b1;
                last_e = cyc;
            end
        end
        m_level = samp_hist[0];
        #1;
        check_bit("sq_level",    bus.sq_level,    m_level);
        check_vec("half_period", bus.half_period, m_hp);
        check_bit("meas_valid",  bus.meas_valid,  m_valid);
        check_bit("locked",      bus.locked,      m_locked);
        check_bit("overflow",    bus.overflow,    m_ovf);
    endtask

    task automatic toggle_wait(input int n);
        bus.sq_in = ~bus.sq_in;
        repeat (n) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        bus.sq_in = 1'b0;
        model_reset();

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();

        // Divide-by-10 source: toggle every 5 cycles
        repeat (8) toggle_wait(5);

        // Directed latency check on a known 5-cycle interval
        bus.sq_in = ~bus.sq_in;
        tick(); check_bit("lat_k",   bus.meas_valid, 1'b0);
        tick(); check_bit("lat_k1",  bus.meas_valid, 1'b0);
        tick(); check_bit("lat_k2",  bus.meas_valid, 1'b1);
                check_vec("lat_hp",  bus.half_period, CNT_W'(5));
        tick(); check_bit("lat_k3",  bus.meas_valid, 1'b0);
        repeat (1) tick();

        // Ratio change to toggle-every-7
        repeat (6) toggle_wait(7);

        // Stuck input well past saturation, then recovery
        toggle_wait(5);
        toggle_wait(300);
        check_bit("stuck_ovf",  bus.overflow, 1'b1);
        check_bit("stuck_lock", bus.locked,   1'b0);
        toggle_wait(5);
        toggle_wait(5);
        toggle_wait(5);

        // Edge exactly at counter saturation
        toggle_wait(5);
        toggle_wait(SAT_SPAN);
        toggle_wait(5);
        toggle_wait(5);
        check_vec("sat_hp", bus.half_period, CNT_W'(5));

        // Reset in the middle of an interval
        repeat (3) toggle_wait(5);
        toggle_wait(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) toggle_wait(5);

        // Shortest intervals
        repeat (6) toggle_wait(1);
        repeat (4) toggle_wait(2);

        // Random intervals, with occasional spans around saturation
        repeat (150) begin
            if ($urandom_range(0, 9) == 0) n = $urandom_range(SAT_SPAN - 6, SAT_SPAN + 4);
            else                           n = $urandom_range(1, 9);
            toggle_wait(n);
        end

        repeat (8) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
